// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the hazard/branch logic (master) and the stall controller (slave).
// Carries hazard inputs, pipeline-register enables and the optional perf counters.
interface pipeline_stall_controller_if #(
    parameter int CNT_W   = 32,
    parameter int STALL_W = 2
);
    logic [1:0]         hazard_code;
    logic               branch_taken;
    logic               jump_taken;
    logic               halt;
    logic               pc_write;
    logic               if_id_write;
    logic               if_id_flush;
    logic               id_ex_bubble;
    logic               busy;
    logic [STALL_W-1:0] stall_left;
    logic [CNT_W-1:0]   stall_cycles;
    logic [CNT_W-1:0]   flush_count;

    modport master (
        output hazard_code, branch_taken, jump_taken, halt,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, busy,
        input  stall_left, stall_cycles, flush_count
    );

    modport slave (
        input  hazard_code, branch_taken, jump_taken, halt,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, busy,
        output stall_left, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush/halt sequencer for the 5-stage core; outputs are combinational.
// Optional perf counters (stall_cycles, flush_count) are enabled by defining STALL_PERF_CNT_EN.
module pipeline_stall_controller #(
    parameter int CNT_W   = 32,
    parameter int STALL_W = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pipeline_stall_controller_if.slave   ctl
);
    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_STALL = 2'd1, ST_HALT = 2'd2} state_t;

    state_t             state_reg, state_next;
    state_t             ret_reg, ret_next;
    state_t             eff_state;
    logic [STALL_W-1:0] stall_left_reg, stall_left_next;
    logic               pc_write_c, if_id_write_c, if_id_flush_c, id_ex_bubble_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_RUN;
            ret_reg        <= ST_RUN;
            stall_left_reg <= '0;
        end else begin
            state_reg      <= state_next;
            ret_reg        <= ret_next;
            stall_left_reg <= stall_left_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ret_next        = ret_reg;
        stall_left_next = stall_left_reg;
        pc_write_c      = 1'b1;
        if_id_write_c   = 1'b1;
        if_id_flush_c   = 1'b0;
        id_ex_bubble_c  = 1'b0;
        // Leaving HALT acts as the saved state in the same cycle, so resume costs no extra cycle.
        eff_state       = (state_reg == ST_HALT) ? ret_reg : state_reg;

        if (ctl.halt) begin
            state_next    = ST_HALT;
            if (state_reg != ST_HALT)
                ret_next = state_reg;
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
        end else if (eff_state == ST_STALL) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_bubble_c = 1'b1;
            if (stall_left_reg != '0)
                stall_left_next = stall_left_reg - 1'b1;
            state_next = (stall_left_reg <= STALL_W'(1)) ? ST_RUN : ST_STALL;
        end else if (ctl.hazard_code != 2'b00) begin
            // The branch in ID is held and re-resolved once the hazard clears.
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_bubble_c = 1'b1;
            if (ctl.hazard_code == 2'b01) begin
                state_next      = ST_STALL;
                stall_left_next = STALL_W'(1);
            end else begin
                state_next      = ST_RUN;
                stall_left_next = '0;
            end
        end else begin
            state_next    = ST_RUN;
            if_id_flush_c = ctl.branch_taken | ctl.jump_taken;
        end

        if (!rst_n) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !ctl.halt && eff_state == ST_STALL)
            assert (stall_left_reg != '0);
    end

    assign ctl.pc_write     = pc_write_c;
    assign ctl.if_id_write  = if_id_write_c;
    assign ctl.if_id_flush  = if_id_flush_c;
    assign ctl.id_ex_bubble = id_ex_bubble_c;
    assign ctl.busy         = (state_reg != ST_RUN);
    assign ctl.stall_left   = stall_left_reg;

`ifdef STALL_PERF_CNT_EN
    logic [1:0] cnt_inc;
    assign cnt_inc = {if_id_flush_c, id_ex_bubble_c};

    // Index 0 counts bubble cycles, index 1 counts flushes; both saturate.
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (!rst_n)
                cnt_reg <= '0;
            else if (cnt_inc[gi] && cnt_reg != '1)
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign ctl.stall_cycles = g_perf[0].cnt_reg;
    assign ctl.flush_count  = g_perf[1].cnt_reg;
`else
    assign ctl.stall_cycles = '0;
    assign ctl.flush_count  = '0;
`endif
endmodule
